tib_loader: RTL

//  Byte-stream writer for the terminal input buffer (TIB): accepts one text line on a

---
 rtl/tib_loader.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/tib_loader.sv
// tib_loader: writes one text line from a valid/ready byte stream into the
// terminal input buffer (TIB) in spram, appends a 0x00 terminator, then frees
// the memory port and the eJ32 core until done_i hands the buffer back.
// CR is dropped and LF ends the line. A line that reaches TIB_SZ-1 stored bytes
// is truncated, and ovf_o is set.
// Optional feature: define TIB_ECHO_EN to echo every accepted byte on
// echo_vld/echo_dat. When it is undefined, both echo outputs are tied to zero.
module tib_loader #(
  parameter int TIB    = 'h1000,
  parameter int TIB_SZ = 'h400,
  parameter int ASZ    = 17
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_vld,
  input  logic [7:0]                in_dat,
  output logic                      in_rdy,
  output logic                      mem_own,
  output logic                      mem_we,
  output logic [ASZ-1:0]            mem_addr,
  output logic [7:0]                mem_wdat,
  output logic                      hold_o,
  output logic [$clog2(TIB_SZ)-1:0] len_o,
  output logic                      ovf_o,
  input  logic                      done_i,
  output logic                      echo_vld,
  output logic [7:0]                echo_dat
);

  localparam int PW = $clog2(TIB_SZ);

  typedef enum logic [1:0] {FILL = 2'd0, TERM = 2'd1, RUN = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic            mem_own_q, mem_own_d;
  logic            hold_q, hold_d;
  logic            mem_we_q, mem_we_d;
  logic [ASZ-1:0]  mem_addr_q, mem_addr_d;
  logic [7:0]      mem_wdat_q, mem_wdat_d;
  logic [PW-1:0]   len_q, len_d;
  logic            ovf_q, ovf_d;
  logic            accept;
  logic [ASZ-1:0]  cur_addr;

  // A byte is taken only in FILL; in_rdy comes straight from the state register.
  assign in_rdy   = (state_q == FILL);
  assign accept   = in_vld && in_rdy;
  // ptr_q < TIB_SZ always holds, so this address stays inside the buffer.
  assign cur_addr = ASZ'(TIB) + ASZ'(ptr_q);

  // Next-state and registered-output logic for the FILL -> TERM -> RUN loop.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    mem_own_d  = mem_own_q;
    hold_d     = hold_q;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_wdat_d = mem_wdat_q;
    len_d      = len_q;
    ovf_d      = ovf_q;
    unique case (state_q)
      FILL: begin
        if (accept) begin
          if (in_dat == 8'h0A) begin
            state_d = TERM;
          end else if (in_dat != 8'h0D) begin
            mem_we_d   = 1'b1;
            mem_addr_d = cur_addr;
            mem_wdat_d = in_dat;
            ptr_d      = ptr_q + 1'b1;
            // One slot is reserved for the terminator. Stop when it is the only slot left.
            if (ptr_q == PW'(TIB_SZ - 2)) begin
              ovf_d   = 1'b1;
              state_d = TERM;
            end
          end
        end
      end
      TERM: begin
        // The terminator write leaves while mem_own is still high. Ownership drops one cycle later.
        mem_we_d   = 1'b1;
        mem_addr_d = cur_addr;
        mem_wdat_d = 8'h00;
        len_d      = ptr_q;
        state_d    = RUN;
      end
      RUN: begin
        mem_own_d = 1'b0;
        hold_d    = 1'b0;
        if (done_i) begin
          ptr_d     = '0;
          ovf_d     = 1'b0;
          hold_d    = 1'b1;
          mem_own_d = 1'b1;
          state_d   = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FILL;
      ptr_q      <= '0;
      mem_own_q  <= 1'b1;
      hold_q     <= 1'b1;
      mem_we_q   <= 1'b0;
      mem_addr_q <= ASZ'(TIB);
      mem_wdat_q <= 8'h00;
      len_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      mem_own_q  <= mem_own_d;
      hold_q     <= hold_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_wdat_q <= mem_wdat_d;
      len_q      <= len_d;
      ovf_q      <= ovf_d;
    end
  end

  assign mem_own  = mem_own_q;
  assign hold_o   = hold_q;
  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_wdat = mem_wdat_q;
  assign len_o    = len_q;
  assign ovf_o    = ovf_q;

`ifdef TIB_ECHO_EN
  logic       echo_vld_q, echo_vld_d;
  logic [7:0] echo_dat_q, echo_dat_d;

  // The echo fires for every accepted byte, CR and LF included. It appears in the same cycle as the write slot.
  always_comb begin
    echo_vld_d = accept;
    echo_dat_d = accept ? in_dat : echo_dat_q;
  end

  // Echo registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      echo_vld_q <= 1'b0;
      echo_dat_q <= 8'h00;
    end else begin
      echo_vld_q <= echo_vld_d;
      echo_dat_q <= echo_dat_d;
    end
  end

  assign echo_vld = echo_vld_q;
  assign echo_dat = echo_dat_q;
`else
  assign echo_vld = 1'b0;
  assign echo_dat = 8'h00;
`endif

endmodule
